// File: rtl/smd_six_button_if.sv
// ---------------------------------------------------------------------------
// smd_six_button_if
//   Bundle of the signals between a six-button Mega Drive pad encoder and
//   the outside world: console select line, the 12 button levels, the six
//   pad pins and a debug view of the TH fall counter.
//
//   There is no handshake: every signal is a plain level. Inputs may change
//   at any time (asynchronous to clk). Outputs are registered.
//
//   Signals
//     p7                  TH select from the console
//     up,dw,lf,rg         d-pad, 0 = pressed
//     a,b,c,st            A, B, C, Start, 0 = pressed
//     x,y,z,md            X, Y, Z, Mode, 0 = pressed
//     p[5:0]              pad pins {pin1,pin2,pin3,pin4,pin6,pin9}
//     dbg_f[2:0]          current TH fall count (0..5)
//
//   Modports
//     master  drives p7 and the buttons, observes p and dbg_f
//     slave   the encoder: samples p7 and buttons, drives p and dbg_f
// ---------------------------------------------------------------------------
interface smd_six_button_if;
    logic       p7;
    logic       up;
    logic       dw;
    logic       lf;
    logic       rg;
    logic       a;
    logic       b;
    logic       c;
    logic       st;
    logic       x;
    logic       y;
    logic       z;
    logic       md;
    logic [5:0] p;
    logic [2:0] dbg_f;

    modport master (
        output p7, up, dw, lf, rg, a, b, c, st, x, y, z, md,
        input  p, dbg_f
    );

    modport slave (
        input  p7, up, dw, lf, rg, a, b, c, st, x, y, z, md,
        output p, dbg_f
    );
endinterface

// File: rtl/smd_six_button.sv
// ---------------------------------------------------------------------------
// smd_six_button
//   Sega Mega Drive six-button pad encoder. The console toggles TH (p7) and
//   reads the six data pins; the number of TH falling edges since the last
//   idle timeout selects between 3-button data, the 6-button ID nibble,
//   the extended X/Y/Z/Mode data and the post-extended all-ones nibble.
//
//   Ports
//     clk     in   system clock, all logic on the rising edge
//     rst_n   in   synchronous, active-low reset
//     pad     if   smd_six_button_if.slave: p7 and buttons in, p and dbg_f out
//
//   Parameters
//     CLK_HZ      system clock frequency in Hz
//     TIMEOUT_US  TH-idle time that restarts the edge sequence
// ---------------------------------------------------------------------------
module smd_six_button #(
    parameter int CLK_HZ     = 10_000_000,
    parameter int TIMEOUT_US = 1500
) (
    input  logic                  clk,
    input  logic                  rst_n,
    smd_six_button_if.slave       pad
);

    localparam int TO_CYCLES = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int IDLE_W    = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TO_CYCLES - 1);

    // Fall-count state. F5 is the saturated state: it shows 3-button rows
    // until an idle timeout brings the sequence back to F0.
    typedef enum logic [2:0] {
        F0 = 3'd0,
        F1 = 3'd1,
        F2 = 3'd2,
        F3 = 3'd3,
        F4 = 3'd4,
        F5 = 3'd5
    } f_state_t;

    // Synchronizers. Reset value 1 = released button / TH high.
    logic              r_th_s1;
    logic              r_th_s;
    logic              r_th_prev;
    logic [11:0]       r_btn_s1;
    logic [11:0]       r_btn_s;

    logic [IDLE_W-1:0] r_idle;
    f_state_t          r_f;
    f_state_t          w_f_next;
    logic [5:0]        r_p;
    logic [5:0]        w_p_next;

    logic              w_edge;
    logic              w_fall;
    logic              w_timeout;
    logic [11:0]       w_btn_raw;

    logic w_up, w_dw, w_lf, w_rg, w_a, w_b, w_c, w_st, w_x, w_y, w_z, w_md;

    assign w_btn_raw = {pad.up, pad.dw, pad.lf, pad.rg,
                        pad.a,  pad.b,  pad.c,  pad.st,
                        pad.x,  pad.y,  pad.z,  pad.md};

    assign {w_up, w_dw, w_lf, w_rg, w_a, w_b, w_c, w_st,
            w_x, w_y, w_z, w_md} = r_btn_s;

    assign w_edge    = r_th_s != r_th_prev;
    assign w_fall    = r_th_prev & ~r_th_s;
    assign w_timeout = r_idle == IDLE_MAX;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_th_s1   <= 1'b1;
            r_th_s    <= 1'b1;
            r_th_prev <= 1'b1;
            r_btn_s1  <= '1;
            r_btn_s   <= '1;
        end else begin
            r_th_s1   <= pad.p7;
            r_th_s    <= r_th_s1;
            r_th_prev <= r_th_s;
            r_btn_s1  <= w_btn_raw;
            r_btn_s   <= r_btn_s1;
        end
    end

    // Idle counter: cleared by any TH edge, otherwise counts up and parks at
    // IDLE_MAX so the timeout stays asserted instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idle <= '0;
        end else if (w_edge) begin
            r_idle <= '0;
        end else if (!w_timeout) begin
            r_idle <= r_idle + IDLE_W'(1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_f <= F0;
            r_p <= 6'b111111;
        end else begin
            r_f <= w_f_next;
            r_p <= w_p_next;
        end
    end

    // Next fall count. An edge in the same cycle as the timeout wins, since
    // the timeout test only runs in the no-edge branch.
    always_comb begin
        w_f_next = r_f;
        if (w_edge) begin
            if (w_fall && (r_f != F5)) begin
                w_f_next = f_state_t'(r_f + 3'd1);
            end
        end else if (w_timeout) begin
            w_f_next = F0;
        end
    end

    // Output row selected from the synchronized TH level and the fall count
    // that will be in effect after this edge, so p and f update together.
    always_comb begin
        w_p_next = {w_up, w_dw, w_lf, w_rg, w_b, w_c};
        if (r_th_s) begin
            if (w_f_next == F3) begin
                w_p_next = {w_z, w_y, w_x, w_md, w_b, w_c};
            end
        end else begin
            case (w_f_next)
                F3:      w_p_next = {4'b0000, w_a, w_st};
                F4:      w_p_next = {4'b1111, w_a, w_st};
                default: w_p_next = {w_up, w_dw, 2'b00, w_a, w_st};
            endcase
        end
    end

    assign pad.p     = r_p;
    assign pad.dbg_f = r_f;

endmodule

// File: tb/tb_smd_six_button.sv
// ---------------------------------------------------------------------------
// tb_smd_six_button
//   Directed bench for the six-button pad encoder. The clock is scaled to
//   2 MHz so one TH phase of 13 us is 26 cycles and the 1.5 ms timeout is
//   3000 cycles; the idle waits of 1.6 ms / 1.0 ms become 3200 / 2000 cycles.
//   Each round starts after TH has been low long enough for the timeout to
//   clear the fall count, then toggles TH ten times.
// ---------------------------------------------------------------------------
module tb_smd_six_button;

    localparam int CLK_HZ     = 2_000_000;
    localparam int TIMEOUT_US = 1500;
    localparam int PHASE_CYC  = 26;
    localparam int IDLE_LONG  = 3200;
    localparam int IDLE_SHORT = 2000;
    localparam int N_VALS     = 11;

    // Button vector order: {up,dw,lf,rg,a,b,c,st,x,y,z,md}
    localparam logic [11:0] BTN_NONE  = 12'hFFF;
    localparam logic [11:0] BTN_X_MD  = 12'hFF6;
    localparam logic [11:0] BTN_Y_MD  = 12'hFFA;
    localparam logic [11:0] BTN_A     = 12'hF7F;
    localparam logic [11:0] BTN_A_UP  = 12'h77F;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    smd_six_button_if pad_if ();

    smd_six_button #(
        .CLK_HZ     (CLK_HZ),
        .TIMEOUT_US (TIMEOUT_US)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pad   (pad_if.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // ---------------- scoreboard ----------------
    logic [5:0] exp_q[$];

    logic [5:0] seq_base [N_VALS] =
        '{6'h33, 6'h3F, 6'h33, 6'h3F, 6'h33, 6'h3F, 6'h03, 6'h3F, 6'h3F, 6'h3F, 6'h33};

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_buttons(input logic [11:0] v);
        {pad_if.up, pad_if.dw, pad_if.lf, pad_if.rg,
         pad_if.a,  pad_if.b,  pad_if.c,  pad_if.st,
         pad_if.x,  pad_if.y,  pad_if.z,  pad_if.md} = v;
    endtask

    // Checks the current (pre-toggle) value, then toggles TH ten times and
    // checks each phase 4 clk after the toggle and again just before the
    // next toggle, consuming exp_q in order.
    task automatic play_round(input string tag);
        logic [5:0] e;
        e = exp_q.pop_front();
        n_checks++;
        if (pad_if.p !== e) $display("FAIL %s[0]: p=%h expected %h", tag, pad_if.p, e);
        else n_pass++;
        for (int i = 1; i < N_VALS; i++) begin
            pad_if.p7 = ~pad_if.p7;
            e = exp_q.pop_front();
            wait_clk(4);
            n_checks++;
            if (pad_if.p !== e) $display("FAIL %s[%0d] early: p=%h expected %h", tag, i, pad_if.p, e);
            else n_pass++;
            wait_clk(PHASE_CYC - 4);
            n_checks++;
            if (pad_if.p !== e) $display("FAIL %s[%0d] late: p=%h expected %h", tag, i, pad_if.p, e);
            else n_pass++;
        end
    endtask

    task automatic push_seq(input int ext_idx, input logic [5:0] ext_val);
        exp_q.delete();
        for (int i = 0; i < N_VALS; i++) begin
            exp_q.push_back((i == ext_idx) ? ext_val : seq_base[i]);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        pad_if.p7 = 1'b1;
        set_buttons(BTN_NONE);
        wait_clk(4);
        n_checks++;
        if (pad_if.p !== 6'h3F) $display("FAIL reset_p: p=%h expected 3f", pad_if.p);
        else n_pass++;
        n_checks++;
        if (pad_if.dbg_f !== 3'd0) $display("FAIL reset_f: f=%0d expected 0", pad_if.dbg_f);
        else n_pass++;
        rst_n = 1'b1;
        wait_clk(8);
        n_checks++;
        if (pad_if.p !== 6'h3F) $display("FAIL post_reset_p: p=%h expected 3f", pad_if.p);
        else n_pass++;
    endtask

    task automatic test_sequence();
        pad_if.p7 = 1'b0;
        wait_clk(IDLE_LONG);
        n_checks++;
        if (pad_if.dbg_f !== 3'd0) $display("FAIL seq_start_f: f=%0d expected 0", pad_if.dbg_f);
        else n_pass++;
        push_seq(-1, 6'h00);
        play_round("seq");
    endtask

    task automatic test_extended();
        // x,md pressed: extended row {z,y,x,md,b,c} = 110011
        set_buttons(BTN_X_MD);
        wait_clk(IDLE_LONG);
        push_seq(7, 6'h33);
        play_round("ext_x_md");
        // y,md pressed: extended row = 101011
        set_buttons(BTN_Y_MD);
        wait_clk(IDLE_LONG);
        push_seq(7, 6'h2B);
        play_round("ext_y_md");
        set_buttons(BTN_NONE);
    endtask

    task automatic test_timeout_restart();
        for (int r = 0; r < 3; r++) begin
            wait_clk(IDLE_LONG);
            n_checks++;
            if (pad_if.dbg_f !== 3'd0) $display("FAIL restart%0d_f: f=%0d expected 0", r, pad_if.dbg_f);
            else n_pass++;
            push_seq(-1, 6'h00);
            play_round($sformatf("restart%0d", r));
        end
    endtask

    task automatic test_no_restart();
        for (int r = 0; r < 2; r++) begin
            wait_clk(IDLE_SHORT);
            n_checks++;
            if (pad_if.dbg_f !== 3'd5) $display("FAIL norestart%0d_f: f=%0d expected 5", r, pad_if.dbg_f);
            else n_pass++;
            exp_q.delete();
            for (int i = 0; i < N_VALS; i++) exp_q.push_back((i % 2 == 1) ? 6'h3F : 6'h33);
            play_round($sformatf("norestart%0d", r));
        end
    endtask

    task automatic test_buttons();
        // TH low, f saturated: row {up,dw,0,0,a,st}
        set_buttons(BTN_A);
        wait_clk(3);
        n_checks++;
        if (pad_if.p !== 6'h31) $display("FAIL btn_a: p=%h expected 31", pad_if.p);
        else n_pass++;
        set_buttons(BTN_A_UP);
        wait_clk(3);
        n_checks++;
        if (pad_if.p !== 6'h11) $display("FAIL btn_a_up: p=%h expected 11", pad_if.p);
        else n_pass++;
        n_checks++;
        if (pad_if.dbg_f !== 3'd5) $display("FAIL btn_f: f=%0d expected 5", pad_if.dbg_f);
        else n_pass++;
        set_buttons(BTN_NONE);
        wait_clk(3);
        n_checks++;
        if (pad_if.p !== 6'h33) $display("FAIL btn_release: p=%h expected 33", pad_if.p);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        wait_clk(IDLE_LONG);
        // Three rise/fall pairs bring f to 3 in the low phase.
        for (int i = 0; i < 6; i++) begin
            pad_if.p7 = ~pad_if.p7;
            wait_clk(PHASE_CYC);
        end
        n_checks++;
        if (pad_if.p !== 6'h03) $display("FAIL mid_id: p=%h expected 03", pad_if.p);
        else n_pass++;
        rst_n = 1'b0;
        wait_clk(1);
        n_checks++;
        if (pad_if.p !== 6'h3F) $display("FAIL mid_rst_p: p=%h expected 3f", pad_if.p);
        else n_pass++;
        n_checks++;
        if (pad_if.dbg_f !== 3'd0) $display("FAIL mid_rst_f: f=%0d expected 0", pad_if.dbg_f);
        else n_pass++;
        rst_n = 1'b1;
        // Synchronizers restart high, so the still-low TH registers as a fall.
        wait_clk(4);
        n_checks++;
        if (pad_if.p !== 6'h33) $display("FAIL mid_after_p: p=%h expected 33", pad_if.p);
        else n_pass++;
        n_checks++;
        if (pad_if.dbg_f !== 3'd1) $display("FAIL mid_after_f: f=%0d expected 1", pad_if.dbg_f);
        else n_pass++;
        pad_if.p7 = 1'b1;
        wait_clk(PHASE_CYC);
        n_checks++;
        if (pad_if.p !== 6'h3F) $display("FAIL mid_hi: p=%h expected 3f", pad_if.p);
        else n_pass++;
        pad_if.p7 = 1'b0;
        wait_clk(PHASE_CYC);
        n_checks++;
        if (pad_if.p !== 6'h33) $display("FAIL mid_lo2: p=%h expected 33", pad_if.p);
        else n_pass++;
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        test_reset();
        test_sequence();
        test_extended();
        test_timeout_restart();
        test_no_restart();
        test_buttons();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
